// File: rtl/ram8_arbiter_if.sv
// Request/response and RAM-side bus of the two-port ram8 arbiter.
interface ram8_arbiter_if #(
   parameter int unsigned AW = 3,
   parameter int unsigned DW = 8
);
   logic          req0_valid;
   logic          req0_we;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          req0_ready;
   logic          rsp0_valid;
   logic [DW-1:0] rsp0_rdata;

   logic          req1_valid;
   logic          req1_we;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          req1_ready;
   logic          rsp1_valid;
   logic [DW-1:0] rsp1_rdata;

   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_a;
   logic [DW-1:0] ram_di;
   logic [DW-1:0] ram_do;

   // Requesters plus the RAM macro as seen from outside the arbiter
   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      input  req0_ready, rsp0_valid, rsp0_rdata,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      input  req1_ready, rsp1_valid, rsp1_rdata,
      input  ram_en, ram_we, ram_a, ram_di,
      output ram_do
   );

   // Arbiter side
   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      output req0_ready, rsp0_valid, rsp0_rdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      output req1_ready, rsp1_valid, rsp1_rdata,
      output ram_en, ram_we, ram_a, ram_di,
      input  ram_do
   );
endinterface

// File: rtl/ram8_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared 8x8 single-port RAM.
// Optional post-reset RAM clear: define RAM8_ARB_INIT_CLEAR_EN.
module ram8_arbiter #(
   parameter int unsigned AW = 3,
   parameter int unsigned DW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   ram8_arbiter_if.slave     bus,
   output logic              busy_o
);

   logic          run_c;
   logic          gnt0_c;
   logic          gnt1_c;
   logic          last_q;
   logic          rsp0_valid_q;
   logic          rsp1_valid_q;
   logic [DW-1:0] rsp0_rdata_q;
   logic [DW-1:0] rsp1_rdata_q;

`ifdef RAM8_ARB_INIT_CLEAR_EN
   typedef enum logic {ST_CLEAR, ST_RUN} state_e;

   state_e        state_q;
   logic [AW-1:0] clr_cnt_q;

   // Clear sequencer: walk every address once after reset, then run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else if (state_q == ST_CLEAR) begin
         clr_cnt_q <= clr_cnt_q + AW'(1);
         if (clr_cnt_q == AW'(7)) state_q <= ST_RUN;
      end
   end

   assign run_c  = rst_n & (state_q == ST_RUN);
   assign busy_o = (state_q == ST_CLEAR);
`else
   assign run_c  = rst_n;
   assign busy_o = 1'b0;
`endif

   // Round-robin grant: on a tie the requester that did not win last goes
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (run_c) begin
         gnt0_c = bus.req0_valid & (~bus.req1_valid | last_q);
         gnt1_c = bus.req1_valid & (~bus.req0_valid | ~last_q);
      end
   end

   assign bus.req0_ready = gnt0_c;
   assign bus.req1_ready = gnt1_c;

   // RAM drive: winner's access in run, clear writes in clear, zero when idle
   always_comb begin
      bus.ram_en = 1'b0;
      bus.ram_we = 1'b0;
      bus.ram_a  = '0;
      bus.ram_di = '0;
      if (run_c) begin
         bus.ram_en = bus.req0_valid | bus.req1_valid;
         if (gnt0_c) begin
            bus.ram_we = bus.req0_we;
            bus.ram_a  = bus.req0_addr;
            bus.ram_di = bus.req0_wdata;
         end else if (gnt1_c) begin
            bus.ram_we = bus.req1_we;
            bus.ram_a  = bus.req1_addr;
            bus.ram_di = bus.req1_wdata;
         end
      end
`ifdef RAM8_ARB_INIT_CLEAR_EN
      else if (rst_n && state_q == ST_CLEAR) begin
         bus.ram_en = 1'b1;
         bus.ram_we = 1'b1;
         bus.ram_a  = clr_cnt_q;
      end
`endif
   end

   // Winner history and registered read responses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q       <= 1'b1;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
      end else begin
         if (gnt0_c)      last_q <= 1'b0;
         else if (gnt1_c) last_q <= 1'b1;
         rsp0_valid_q <= gnt0_c & ~bus.req0_we;
         rsp1_valid_q <= gnt1_c & ~bus.req1_we;
         if (gnt0_c && !bus.req0_we) rsp0_rdata_q <= bus.ram_do;
         if (gnt1_c && !bus.req1_we) rsp1_rdata_q <= bus.ram_do;
      end
   end

   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp0_rdata = rsp0_rdata_q;
   assign bus.rsp1_rdata = rsp1_rdata_q;

endmodule
